fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, as the first fetch address after reset.
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL provide port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL provide port imem_addr, output, 32 bits: byte address presented to the combinational instruction memory.
REQ-005 The block SHALL provide port imem_rd, input, 32 bits: instruction word returned by memory in the same cycle for imem_addr.
REQ-006 The block SHALL provide port branch_valid, input, 1 bit: a one-cycle redirect request.
REQ-007 The block SHALL provide port branch_target, input, 32 bits: the redirect byte address.
REQ-008 The block SHALL provide port instr_valid, output, 1 bit: the head instruction is valid.
REQ-009 The block SHALL provide port instr_ready, input, 1 bit: the decoder accepts the head this cycle.
REQ-010 The block SHALL provide port instr, output, 32 bits: the head instruction word.
REQ-011 The block SHALL provide port instr_pc, output, 32 bits: the byte address of the head instruction.
REQ-012 The block SHALL provide port pc_plus8, output, 32 bits: instr_pc + 8, the ARM architectural PC read value.
REQ-013 The block SHALL provide port fault, output, 1 bit: sticky misaligned-branch flag.

Function
REQ-014 The block SHALL keep an internal fetch PC register; imem_addr SHALL equal the fetch PC combinationally.
REQ-015 The block SHALL keep a 2-entry FIFO of {word, pc}, controlled by a 3-state machine: EMPTY, ONE, FULL.
REQ-016 Pop SHALL occur when instr_valid and instr_ready are both 1.
REQ-017 Push SHALL occur when there is no branch and (state != FULL or pop); a push writes {imem_rd, fetch PC} and advances PC by 4.
REQ-018 PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 State transitions SHALL be: push only -> +1 entry; pop only -> -1 entry; push and pop together -> unchanged.
REQ-020 instr_valid SHALL be 1 exactly when state != EMPTY; instr and instr_pc SHALL show the oldest entry.
REQ-021 When state is EMPTY, instr and instr_pc SHALL hold their last values, and instr_valid SHALL be 0.
REQ-022 On branch_valid=1, the FIFO SHALL flush to EMPTY and PC SHALL load {branch_target[31:2], 2'b00}.
REQ-023 During a branch cycle, no push SHALL occur; a simultaneous pop SHALL be honoured and the branch SHALL take priority for next state.
REQ-024 Fetch-to-valid latency SHALL be 1 cycle: a word pushed at edge N is visible with instr_valid=1 after edge N.
REQ-025 With instr_ready held at 1, the block SHALL sustain one instruction per cycle.
REQ-026 With instr_ready at 0, the block SHALL fill to FULL and then hold the PC.

Reset
REQ-027 While reset_n=0, the outputs SHALL be: PC=RESET_PC, state=EMPTY, instr_valid=0, instr=0, instr_pc=0, pc_plus8=8, fault=0.
REQ-028 Reset asserted mid-operation SHALL discard all FIFO contents immediately, without waiting for a clock edge.
REQ-029 The first fetch SHALL occur on the first rising edge after reset_n deasserts.

Configuration
REQ-030 With the macro FETCH_ALIGN_CHECK_EN defined, a branch whose target has bits [1:0] != 0 SHALL set fault and flush the FIFO.
REQ-031 With FETCH_ALIGN_CHECK_EN defined, a faulting branch SHALL also freeze PC with no further pushes until reset.
REQ-032 Without FETCH_ALIGN_CHECK_EN, target bits [1:0] SHALL be silently cleared and fault SHALL be tied to 0.

Verification
REQ-033 Reset release with RESET_PC=0 and ready=1 -> imem_addr 0,4,8 on successive cycles; instr_pc 0,4,8 and pc_plus8 8,12,16 one cycle later.
REQ-034 ready=0 for 5 cycles -> state reaches FULL after 2 pushes; PC holds at 8; on ready=1, entries at pc 0 and 4 drain in order.
REQ-035 FULL state with ready=1 and branch_valid=1 to 32'h100 -> head popped; next cycle instr_valid=0 and imem_addr=32'h100; following cycle instr_pc=32'h100.
REQ-036 PC at 32'hFFFF_FFFC with ready=1 -> next imem_addr is 32'h0000_0000.
REQ-037 reset_n pulsed low mid-stream while FULL -> instr_valid falls to 0 asynchronously; after release, fetch restarts at RESET_PC.
REQ-038 Branch to 32'h102: with FETCH_ALIGN_CHECK_EN defined -> fault=1, instr_valid stays 0, and PC is frozen; without the macro -> fetch continues from 32'h100 and fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a fetch PC driving a combinational instruction
// memory, feeding a 2-entry {word, pc} queue toward the decoder.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a branch
// to a misaligned target sets a sticky fault and freezes fetch until reset.
//
// state | meaning
// EMPTY | no instruction held, instr_valid low
// ONE   | head entry valid, tail slot free
// FULL  | head and tail entries valid, fetch stalls unless head pops
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rd,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus8,
   output logic        fault
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] head_word;
   logic [31:0] head_pc;
   logic [31:0] tail_word;
   logic [31:0] tail_pc;
   logic        pop;
   logic        push;
   logic        take_branch;
   logic        bad_branch;
   logic        frozen;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q;

   // a faulting branch is only recognised once; afterwards fetch is frozen
   assign bad_branch = branch_valid && (branch_target[1:0] != 2'b00) && !fault_q;
   assign frozen     = fault_q;
   assign fault      = fault_q;

   // sticky misaligned-branch flag, cleared only by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_q <= 1'b0;
      end else if (bad_branch) begin
         fault_q <= 1'b1;
      end
   end
`else
   assign bad_branch = 1'b0;
   assign frozen     = 1'b0;
   assign fault      = 1'b0;
`endif

   assign take_branch = branch_valid && !frozen;
   assign instr_valid = (state != EMPTY);
   assign pop         = instr_valid && instr_ready;
   // a full queue can still accept the new word when the head leaves this cycle
   assign push        = !take_branch && !frozen && ((state != FULL) || pop);
   assign imem_addr   = pc;
   assign instr       = head_word;
   assign instr_pc    = head_pc;
   assign pc_plus8    = head_pc + 32'd8;

   // queue occupancy state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // occupancy update: a branch flushes, otherwise push/pop adjust the count
   always_comb begin
      state_nxt = state;
      if (take_branch) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (push) state_nxt = ONE;
            ONE:     if (push && !pop) state_nxt = FULL;
                     else if (!push && pop) state_nxt = EMPTY;
            FULL:    if (!push && pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // fetch PC: redirect on branch (low bits dropped), step by 4 on each push
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc <= RESET_PC;
      end else if (take_branch && !bad_branch) begin
         pc <= branch_target & ~32'h3;
      end else if (push) begin
         pc <= pc + 32'd4;
      end
   end

   // queue storage; head keeps its last contents whenever the queue drains
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_word <= 32'd0;
         head_pc   <= 32'd0;
         tail_word <= 32'd0;
         tail_pc   <= 32'd0;
      end else if (push) begin
         if ((state == EMPTY) || ((state == ONE) && pop)) begin
            head_word <= imem_rd;
            head_pc   <= pc;
         end else if (state == ONE) begin
            tail_word <= imem_rd;
            tail_pc   <= pc;
         end else begin
            head_word <= tail_word;
            head_pc   <= tail_pc;
            tail_word <= imem_rd;
            tail_pc   <= pc;
         end
      end else if (pop && (state == FULL) && !take_branch) begin
         head_word <= tail_word;
         head_pc   <= tail_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver issues ready/branch stimulus
// and predicts the fetched stream into a queue; the monitor compares the DUT
// head against that queue each cycle and retires entries on accept.
module tb_fetch_unit;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } ent_t;

   logic        clk;
   logic        reset_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc_plus8;
   logic        fault;

   int          n_cmp;
   int          n_err;
   ent_t        exp_q[$];
   logic [31:0] model_pc;
   logic        model_fault;
   logic [31:0] disp_word;
   logic [31:0] disp_pc;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_addr     (imem_addr),
      .imem_rd       (imem_rd),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .pc_plus8      (pc_plus8),
      .fault         (fault)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   assign imem_rd = mem(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      exp_q.delete();
      model_pc    = 32'h0000_0000;
      model_fault = 1'b0;
      disp_word   = 32'd0;
      disp_pc     = 32'd0;
   endfunction

   // predicts the edge following the current inputs; the monitor has already
   // removed any entry the decoder accepts this cycle
   function automatic void model_step(input bit br, input logic [31:0] tgt);
      if (model_fault) return;
      if (br) begin
`ifdef FETCH_ALIGN_CHECK_EN
         if (tgt[1:0] != 2'b00) begin
            model_fault = 1'b1;
            exp_q.delete();
            return;
         end
`endif
         exp_q.delete();
         model_pc = tgt & ~32'h3;
         return;
      end
      if (exp_q.size() < 2) begin
         exp_q.push_back(ent_t'{mem(model_pc), model_pc});
         model_pc = model_pc + 32'd4;
      end
   endfunction

   task automatic drive(input bit rdy, input bit br, input logic [31:0] tgt);
      instr_ready   = rdy;
      branch_valid  = br;
      branch_target = tgt;
      #3;
      model_step(br, tgt);
   endtask

   task automatic cycle(input bit rdy, input bit br, input logic [31:0] tgt);
      @(negedge clk);
      drive(rdy, br, tgt);
   endtask

   task automatic do_reset(input bit rdy_after);
      reset_n       = 1'b0;
      instr_ready   = 1'b0;
      branch_valid  = 1'b0;
      branch_target = 32'd0;
      model_reset();
      #1;
      check("reset_async_valid", instr_valid, 32'd0);
      check("reset_instr", instr, 32'd0);
      check("reset_instr_pc", instr_pc, 32'd0);
      check("reset_pc_plus8", pc_plus8, 32'd8);
      check("reset_fault", fault, 32'd0);
      check("reset_imem_addr", imem_addr, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      drive(rdy_after, 1'b0, 32'd0);
   endtask

   // monitor: compares the head against the scoreboard and retires on accept
   always @(negedge clk) begin
      #2;
      check("imem_addr", imem_addr, model_pc);
      check("instr_valid", instr_valid, {31'd0, exp_q.size() != 0});
      check("fault", fault, {31'd0, model_fault});
      if (instr_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got instr_pc %h with no expected entry", instr_pc);
         end else begin
            check("instr", instr, exp_q[0].word);
            check("instr_pc", instr_pc, exp_q[0].pc);
            check("pc_plus8", pc_plus8, exp_q[0].pc + 32'd8);
            disp_word = exp_q[0].word;
            disp_pc   = exp_q[0].pc;
            if (instr_ready) void'(exp_q.pop_front());
         end
      end else begin
         check("hold_instr", instr, disp_word);
         check("hold_instr_pc", instr_pc, disp_pc);
      end
   end

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      reset_n       = 1'b1;
      instr_ready   = 1'b0;
      branch_valid  = 1'b0;
      branch_target = 32'd0;
      model_reset();
      #2;

      // streaming from reset with the decoder always ready
      do_reset(1'b1);
      check("start_addr", imem_addr, 32'h0);
      cycle(1'b1, 1'b0, 32'd0);
      check("s1_addr", imem_addr, 32'h4);
      check("s1_pc", instr_pc, 32'h0);
      check("s1_p8", pc_plus8, 32'h8);
      cycle(1'b1, 1'b0, 32'd0);
      check("s2_addr", imem_addr, 32'h8);
      check("s2_pc", instr_pc, 32'h4);
      check("s2_p8", pc_plus8, 32'hC);
      cycle(1'b1, 1'b0, 32'd0);
      check("s3_pc", instr_pc, 32'h8);
      check("s3_p8", pc_plus8, 32'h10);

      // stall fills the queue and holds the PC, then drains in order
      do_reset(1'b0);
      repeat (5) cycle(1'b0, 1'b0, 32'd0);
      check("stall_addr", imem_addr, 32'h8);
      check("stall_valid", instr_valid, 32'd1);
      check("stall_pc", instr_pc, 32'h0);
      cycle(1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 32'd0);
      check("drain_pc", instr_pc, 32'h4);

      // branch from a full queue while the head is accepted
      cycle(1'b1, 1'b1, 32'h100);
      cycle(1'b1, 1'b0, 32'd0);
      check("br_valid", instr_valid, 32'd0);
      check("br_addr", imem_addr, 32'h100);
      cycle(1'b1, 1'b0, 32'd0);
      check("br_pc", instr_pc, 32'h100);

      // PC wraps at the top of the address space
      cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
      cycle(1'b1, 1'b0, 32'd0);
      check("wrap_top", imem_addr, 32'hFFFF_FFFC);
      cycle(1'b1, 1'b0, 32'd0);
      check("wrap_zero", imem_addr, 32'h0);

      // reset asserted mid-stream while full
      do_reset(1'b0);
      repeat (3) cycle(1'b0, 1'b0, 32'd0);
      check("pre_rst_valid", instr_valid, 32'd1);
      do_reset(1'b1);
      cycle(1'b1, 1'b0, 32'd0);
      check("rst_restart_pc", instr_pc, 32'h0);
      check("rst_restart_addr", imem_addr, 32'h4);

      // misaligned branch target
      do_reset(1'b1);
      cycle(1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 32'h102);
      cycle(1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      check("mis_fault", fault, 32'd1);
      check("mis_valid", instr_valid, 32'd0);
      check("mis_frozen", imem_addr, 32'hC);
      cycle(1'b1, 1'b1, 32'h200);
      repeat (3) cycle(1'b1, 1'b0, 32'd0);
      check("mis_still_frozen", imem_addr, 32'hC);
`else
      check("mis_fault", fault, 32'd0);
      check("mis_pc", instr_pc, 32'h100);
      check("mis_addr", imem_addr, 32'h104);
`endif

      // randomized traffic against the scoreboard
      do_reset(1'b1);
      for (int i = 0; i < 500; i++) begin
         bit          rdy;
         bit          br;
         logic [31:0] tgt;
         rdy = ($urandom_range(0, 3) != 0);
         br  = ($urandom_range(0, 11) == 0);
         tgt = $urandom;
         if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
`ifdef FETCH_ALIGN_CHECK_EN
         tgt = tgt & ~32'h3;
`endif
         cycle(rdy, br, tgt);
      end

      @(negedge clk);
      #4;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
